// File: rtl/moving_avg_filter.sv
// Boxcar moving-average stage fed by the DDS tap shift register.
// Keeps acc = sum of the last N samples and emits round(acc / N).
module moving_avg_filter #(
  parameter int SIG_WIDTH = 16,
  parameter int ACC_WIDTH = SIG_WIDTH + 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic signed [SIG_WIDTH-1:0] din,
  input  logic [2:0]                  len_sel,
  input  logic                        clr,
  output logic                        sr_en,
  output logic                        sr_clr,
  input  logic signed [SIG_WIDTH-1:0] tap_8,
  input  logic signed [SIG_WIDTH-1:0] tap_16,
  input  logic signed [SIG_WIDTH-1:0] tap_32,
  input  logic signed [SIG_WIDTH-1:0] tap_64,
  input  logic signed [SIG_WIDTH-1:0] tap_128,
  input  logic signed [SIG_WIDTH-1:0] tap_256,
  output logic signed [SIG_WIDTH-1:0] dout,
  output logic                        dout_vld,
  output logic                        busy
);

  localparam int XW = ACC_WIDTH - SIG_WIDTH;

  typedef enum logic [1:0] {
    FLUSH = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [2:0]                  r_len_q;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic [8:0]                  r_cnt;
  logic signed [SIG_WIDTH-1:0] r_dout;
  logic                        r_dout_vld;
  logic                        r_sr_clr;

  logic                        w_is8;
  logic                        w_is16;
  logic                        w_is32;
  logic                        w_is64;
  logic                        w_is128;
  logic                        w_is256;
  logic signed [SIG_WIDTH-1:0] w_tap;
  logic [3:0]                  w_k;
  logic [8:0]                  w_last;
  logic                        w_restart;
  logic                        w_accept;
  logic                        w_emit;
  logic signed [ACC_WIDTH-1:0] w_din_x;
  logic signed [ACC_WIDTH-1:0] w_tap_x;
  logic signed [ACC_WIDTH-1:0] w_sum;
  logic signed [ACC_WIDTH-1:0] w_rnd;
  logic signed [SIG_WIDTH-1:0] w_avg;

  // Length decode always comes from the latched code, so a
  // live len_sel change cannot corrupt the window in flight.
  assign w_is8   = (r_len_q == 3'd0);
  assign w_is16  = (r_len_q == 3'd1);
  assign w_is32  = (r_len_q == 3'd2);
  assign w_is64  = (r_len_q == 3'd3);
  assign w_is128 = (r_len_q == 3'd4);
  assign w_is256 = (r_len_q >= 3'd5);

  // Select the x[n-N] tap and log2(N) for the active length
  always_comb begin
    w_tap = '0;
    w_k   = 4'd8;
    unique case (1'b1)
      w_is8: begin
        w_tap = tap_8;
        w_k   = 4'd3;
      end
      w_is16: begin
        w_tap = tap_16;
        w_k   = 4'd4;
      end
      w_is32: begin
        w_tap = tap_32;
        w_k   = 4'd5;
      end
      w_is64: begin
        w_tap = tap_64;
        w_k   = 4'd6;
      end
      w_is128: begin
        w_tap = tap_128;
        w_k   = 4'd7;
      end
      w_is256: begin
        w_tap = tap_256;
        w_k   = 4'd8;
      end
      default: begin
        w_tap = tap_256;
        w_k   = 4'd8;
      end
    endcase
  end

  assign w_last = (9'd1 << w_k) - 9'd1;

  // A clear or a new length throws the window away; in FLUSH
  // len_q is being reloaded, so only clr holds it there.
  assign w_restart = clr | (len_sel != r_len_q);

  assign w_accept = en
                  & (r_state != FLUSH)
                  & ~w_restart;

  // First pulse on the N-th fill sample, then every sample
  assign w_emit = w_accept
                & ((r_state == RUN) | (r_cnt == w_last));

  assign w_din_x = {{XW{din[SIG_WIDTH-1]}}, din};
  assign w_tap_x = {{XW{w_tap[SIG_WIDTH-1]}}, w_tap};
  assign w_sum   = r_acc + w_din_x - w_tap_x;

  // Half-up rounding: add N/2, then arithmetic shift by k
  assign w_rnd = w_sum
               + (ACC_WIDTH'(1) << (w_k - 4'd1));
  assign w_avg = SIG_WIDTH'(w_rnd >>> w_k);

  // Next-state selection for FLUSH -> FILL -> RUN
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      FLUSH: begin
        if (clr) w_next = FLUSH;
        else     w_next = FILL;
      end
      FILL: begin
        if (w_restart)
          w_next = FLUSH;
        else if (en && (r_cnt == w_last))
          w_next = RUN;
      end
      RUN: begin
        if (w_restart) w_next = FLUSH;
      end
      default: w_next = FLUSH;
    endcase
  end

  // State register; sr_clr follows FLUSH as a registered flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= FLUSH;
      r_sr_clr <= 1'b1;
    end else begin
      r_state  <= w_next;
      r_sr_clr <= (w_next == FLUSH);
    end
  end

  // Accumulator, fill counter and latched length
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_len_q <= 3'd0;
    end else if (r_state == FLUSH) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_len_q <= len_sel;
    end else if (w_accept) begin
      r_acc <= w_sum;
      if (r_state == FILL)
        r_cnt <= r_cnt + 9'd1;
    end
  end

  // Output register: dout holds between valid pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout     <= '0;
      r_dout_vld <= 1'b0;
    end else begin
      r_dout_vld <= w_emit;
      if (w_emit)
        r_dout <= w_avg;
    end
  end

  assign sr_en    = en & (r_state != FLUSH);
  assign sr_clr   = r_sr_clr;
  assign dout     = r_dout;
  assign dout_vld = r_dout_vld;
  assign busy     = (r_state != RUN);

endmodule

// File: tb/tb_moving_avg_filter.sv
// Directed bench for moving_avg_filter with a behavioural
// tap shift register and a history-based window average.
module tb_moving_avg_filter;

  localparam int W = 16;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                en = 1'b0;
  logic signed [W-1:0] din = '0;
  logic [2:0]          len_sel = 3'd0;
  logic                clr = 1'b0;
  logic                sr_en;
  logic                sr_clr;
  logic signed [W-1:0] tap_8;
  logic signed [W-1:0] tap_16;
  logic signed [W-1:0] tap_32;
  logic signed [W-1:0] tap_64;
  logic signed [W-1:0] tap_128;
  logic signed [W-1:0] tap_256;
  logic signed [W-1:0] dout;
  logic                dout_vld;
  logic                busy;

  int errs = 0;
  int checks = 0;
  int hist[$];

  logic signed [W-1:0] sr [0:255];

  always #5 clk = ~clk;

  moving_avg_filter #(.SIG_WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .din      (din),
    .len_sel  (len_sel),
    .clr      (clr),
    .sr_en    (sr_en),
    .sr_clr   (sr_clr),
    .tap_8    (tap_8),
    .tap_16   (tap_16),
    .tap_32   (tap_32),
    .tap_64   (tap_64),
    .tap_128  (tap_128),
    .tap_256  (tap_256),
    .dout     (dout),
    .dout_vld (dout_vld),
    .busy     (busy)
  );

  // Upstream shift register: sr[i] holds x[n-1-i]
  always @(posedge clk) begin
    if (sr_clr) begin
      for (int i = 0; i < 256; i++) sr[i] <= '0;
    end else if (sr_en) begin
      sr[0] <= din;
      for (int i = 1; i < 256; i++) sr[i] <= sr[i-1];
    end
  end

  assign tap_8   = sr[7];
  assign tap_16  = sr[15];
  assign tap_32  = sr[31];
  assign tap_64  = sr[63];
  assign tap_128 = sr[127];
  assign tap_256 = sr[255];

  function automatic int exp_avg(input int n);
    real s;
    s = 0.0;
    for (int i = hist.size() - n; i < hist.size(); i++)
      s = s + real'(hist[i]);
    return int'($floor(s / real'(n) + 0.5));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int x);
    din = W'(x);
    en = 1'b1;
    hist.push_back(x);
    tick();
  endtask

  task automatic drop(input int x);
    din = W'(x);
    en = 1'b1;
    tick();
  endtask

  task automatic restart(input logic [2:0] len);
    en = 1'b0;
    clr = 1'b1;
    len_sel = len;
    tick();
    clr = 1'b0;
    checks++;
    if (sr_clr !== 1'b1 || busy !== 1'b1) begin
      errs++;
      $display("FAIL restart_flush: sr_clr=%b busy=%b want 1 1",
               sr_clr, busy);
    end
    tick();
    checks++;
    if (sr_clr !== 1'b0 || busy !== 1'b1) begin
      errs++;
      $display("FAIL restart_fill: sr_clr=%b busy=%b want 0 1",
               sr_clr, busy);
    end
    hist.delete();
  endtask

  // Starting in FLUSH with din=100: one dropped, 8 to fill
  task automatic fill8_const100(input string nm);
    int early;
    early = 0;
    drop(100);
    checks++;
    if (sr_clr !== 1'b0 || busy !== 1'b1 || dout_vld !== 1'b0) begin
      errs++;
      $display("FAIL %s_flush: clr=%b busy=%b vld=%b want 0 1 0",
               nm, sr_clr, busy, dout_vld);
    end
    for (int i = 1; i <= 7; i++) begin
      put(100);
      if (dout_vld !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin
      errs++;
      $display("FAIL %s_early_vld: got %0d pulses want 0", nm, early);
    end
    put(100);
    checks++;
    if (dout_vld !== 1'b1 || dout !== 16'sd100 || busy !== 1'b0) begin
      errs++;
      $display("FAIL %s_first: vld=%b dout=%0d busy=%b want 1 100 0",
               nm, dout_vld, dout, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b1;
    din = 16'sd100;
    len_sel = 3'd0;
    clr = 1'b0;
    repeat (3) tick();
    checks++;
    if (dout !== '0 || dout_vld !== 1'b0 || busy !== 1'b1 ||
        sr_clr !== 1'b1 || sr_en !== 1'b0) begin
      errs++;
      $display("FAIL reset: dout=%0d vld=%b busy=%b clr=%b sren=%b want 0 0 1 1 0",
               dout, dout_vld, busy, sr_clr, sr_en);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_const_n8();
    fill8_const100("const8");
    for (int i = 0; i < 4; i++) begin
      put(100);
      checks++;
      if (dout_vld !== 1'b1 || dout !== 16'sd100) begin
        errs++;
        $display("FAIL const8_run: vld=%b dout=%0d want 1 100",
                 dout_vld, dout);
      end
    end
    en = 1'b0;
    din = 16'sd5;
    tick();
    tick();
    checks++;
    if (dout_vld !== 1'b0 || dout !== 16'sd100) begin
      errs++;
      $display("FAIL const8_idle: vld=%b dout=%0d want 0 100",
               dout_vld, dout);
    end
  endtask

  task automatic test_impulse_n256();
    int early;
    early = 0;
    restart(3'd5);
    for (int i = 1; i <= 256; i++) begin
      put(0);
      if (i < 256 && dout_vld !== 1'b0) early++;
    end
    checks++;
    if (early != 0 || dout_vld !== 1'b1 || dout !== 16'sd0) begin
      errs++;
      $display("FAIL imp_fill: early=%0d vld=%b dout=%0d want 0 1 0",
               early, dout_vld, dout);
    end
    for (int i = 0; i < 256; i++) begin
      put(i == 0 ? 2560 : 0);
      checks++;
      if (dout_vld !== 1'b1 || dout !== 16'sd10) begin
        errs++;
        $display("FAIL imp_out%0d: vld=%b dout=%0d want 1 10",
                 i, dout_vld, dout);
      end
    end
    put(0);
    checks++;
    if (dout_vld !== 1'b1 || dout !== 16'sd0) begin
      errs++;
      $display("FAIL imp_257: vld=%b dout=%0d want 1 0",
               dout_vld, dout);
    end
  endtask

  task automatic test_len_switch();
    int early;
    int want;
    early = 0;
    restart(3'd1);
    for (int i = 0; i < 20; i++) put(i * 123 - 900);
    want = exp_avg(16);
    checks++;
    if (dout_vld !== 1'b1 || int'(dout) !== want) begin
      errs++;
      $display("FAIL sw_n16: vld=%b dout=%0d want 1 %0d",
               dout_vld, dout, want);
    end
    len_sel = 3'd2;
    drop(7);
    checks++;
    if (dout_vld !== 1'b0 || busy !== 1'b1 || sr_clr !== 1'b1) begin
      errs++;
      $display("FAIL sw_flush: vld=%b busy=%b clr=%b want 0 1 1",
               dout_vld, busy, sr_clr);
    end
    drop(9);
    checks++;
    if (dout_vld !== 1'b0 || busy !== 1'b1 || sr_clr !== 1'b0) begin
      errs++;
      $display("FAIL sw_clr_pulse: vld=%b busy=%b clr=%b want 0 1 0",
               dout_vld, busy, sr_clr);
    end
    hist.delete();
    for (int i = 0; i < 31; i++) begin
      put(i * 311 - 4000);
      if (dout_vld !== 1'b0 || busy !== 1'b1) early++;
    end
    checks++;
    if (early != 0) begin
      errs++;
      $display("FAIL sw_fill32: got %0d bad cycles want 0", early);
    end
    for (int i = 31; i < 37; i++) begin
      put(i * 311 - 4000);
      want = exp_avg(32);
      checks++;
      if (dout_vld !== 1'b1 || int'(dout) !== want) begin
        errs++;
        $display("FAIL sw_n32_%0d: vld=%b dout=%0d want 1 %0d",
                 i, dout_vld, dout, want);
      end
    end
  endtask

  task automatic test_rounding();
    restart(3'd0);
    put(-3); put(-3); put(-3); put(-3);
    put(0);  put(0);  put(0);  put(0);
    checks++;
    if (dout_vld !== 1'b1 || dout !== -16'sd1) begin
      errs++;
      $display("FAIL round_neg: vld=%b dout=%0d want 1 -1",
               dout_vld, dout);
    end
    put(3); put(3); put(3); put(3);
    put(0); put(0); put(0); put(0);
    checks++;
    if (dout_vld !== 1'b1 || dout !== 16'sd2) begin
      errs++;
      $display("FAIL round_pos: vld=%b dout=%0d want 1 2",
               dout_vld, dout);
    end
  endtask

  task automatic test_extremes();
    int want;
    int bad;
    bad = 0;
    restart(3'd5);
    for (int i = 0; i < 256; i++) put(32767);
    checks++;
    if (dout_vld !== 1'b1 || dout !== 16'sd32767) begin
      errs++;
      $display("FAIL ext_max: vld=%b dout=%0d want 1 32767",
               dout_vld, dout);
    end
    for (int i = 0; i < 256; i++) begin
      put(-32768);
      want = exp_avg(256);
      if (dout_vld !== 1'b1 || int'(dout) !== want) bad++;
    end
    checks++;
    if (bad != 0) begin
      errs++;
      $display("FAIL ext_ramp_down: got %0d bad outputs want 0", bad);
    end
    checks++;
    if (dout !== -16'sd32768) begin
      errs++;
      $display("FAIL ext_min: dout=%0d want -32768", dout);
    end
    bad = 0;
    for (int i = 0; i < 257; i++) begin
      put((i % 2 == 0) ? 32767 : -32768);
      want = exp_avg(256);
      if (dout_vld !== 1'b1 || int'(dout) !== want) bad++;
    end
    checks++;
    if (bad != 0) begin
      errs++;
      $display("FAIL ext_alt_model: got %0d bad outputs want 0", bad);
    end
    checks++;
    if (dout !== 16'sd0) begin
      errs++;
      $display("FAIL ext_alt: dout=%0d want 0", dout);
    end
  endtask

  task automatic test_reset_mid_run();
    restart(3'd0);
    for (int i = 0; i < 10; i++) put(100);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dout !== '0 || dout_vld !== 1'b0 || busy !== 1'b1 ||
        sr_clr !== 1'b1) begin
      errs++;
      $display("FAIL async_rst: dout=%0d vld=%b busy=%b clr=%b want 0 0 1 1",
               dout, dout_vld, busy, sr_clr);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    len_sel = 3'd0;
    fill8_const100("rst_restart");
    put(100);
    clr = 1'b1;
    drop(100);
    clr = 1'b0;
    checks++;
    if (dout_vld !== 1'b0 || sr_clr !== 1'b1 || busy !== 1'b1) begin
      errs++;
      $display("FAIL clr_pulse: vld=%b clr=%b busy=%b want 0 1 1",
               dout_vld, sr_clr, busy);
    end
    fill8_const100("clr_restart");
  endtask

  initial begin
    test_reset();
    test_const_n8();
    test_impulse_n256();
    test_len_switch();
    test_rounding();
    test_extremes();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
